// File: rtl/lenet_stream_loader.sv
// Streams weights, biases and per-image feature maps from memory to the LeNet
// accelerator through a 2-entry FIFO, then collects one classification per image.
module lenet_stream_loader #(
  parameter int DATA_BW       = 16,
  parameter int ADDR_BW       = 16,
  parameter int N_WEIGHT      = 61706,
  parameter int N_BIAS        = 10,
  parameter int N_FMAP        = 1024,
  parameter int IMG_BW        = 8,
  parameter int RELOAD_PARAMS = 0
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               ce,
  input  logic               i_start,
  input  logic [IMG_BW-1:0]  i_num_img,
  output logic               o_mem_re,
  output logic [1:0]         o_mem_sel,
  output logic [ADDR_BW-1:0] o_mem_addr,
  input  logic [DATA_BW-1:0] i_mem_data,
  output logic [DATA_BW-1:0] o_data,
  output logic               o_data_valid,
  output logic [1:0]         o_phase,
  input  logic               i_data_ready,
  input  logic [3:0]         i_result,
  input  logic               i_result_en,
  output logic               o_busy,
  output logic [IMG_BW-1:0]  o_img_idx,
  output logic [3:0]         o_result,
  output logic               o_result_valid,
  output logic               o_done
);

  typedef enum logic [2:0] {IDLE, LD_W, LD_B, LD_F, WAIT_RES, DONE} state_t;

  state_t             state_q, state_d;
  logic [IMG_BW-1:0]  num_q, num_d, img_q, img_d;
  logic               loaded_q, loaded_d;
  logic [31:0]        rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
  logic               infl_q, infl_d;
  logic [1:0]         infl_ph_q, infl_ph_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]         res_q, res_d;
  logic               res_vld_q, res_vld_d, done_q, done_d;
  logic [DATA_BW-1:0] fifo_data_q [2];
  logic [1:0]         fifo_ph_q [2];

  logic               ld_state, vld, pop, push, last, can_rd, rd_en;
  logic [1:0]         ph_cur;
  logic [31:0]        len;
  logic [2:0]         occ_nxt;
  logic [IMG_BW:0]    img_nx;
  logic [ADDR_BW-1:0] base;

  always_comb begin
    ld_state = 1'b0;
    ph_cur   = 2'd0;
    len      = 32'd0;
    unique case (state_q)
      LD_W: begin ld_state = 1'b1; ph_cur = 2'd0; len = 32'(N_WEIGHT); end
      LD_B: begin ld_state = 1'b1; ph_cur = 2'd1; len = 32'(N_BIAS);   end
      LD_F: begin ld_state = 1'b1; ph_cur = 2'd2; len = 32'(N_FMAP);   end
      default: ;
    endcase
  end

  // A pop in the same cycle frees a slot, which keeps the stream at one element per cycle.
  assign vld     = (cnt_q != 2'd0);
  assign pop     = vld & i_data_ready & ce;
  assign push    = infl_q & ce;
  assign last    = ld_state & pop & (tx_cnt_q == len - 32'd1);
  assign occ_nxt = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign can_rd  = ld_state & (rd_cnt_q < len) & (occ_nxt < 3'd2);
  assign rd_en   = ce & can_rd;
  assign img_nx  = {1'b0, img_q} + {{IMG_BW{1'b0}}, 1'b1};
  assign base    = (state_q == LD_F) ? ADDR_BW'(img_q) * ADDR_BW'(N_FMAP) : '0;

  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
  assign wr_ptr_d  = wr_ptr_q ^ push;
  assign rd_ptr_d  = rd_ptr_q ^ pop;
  assign infl_d    = rd_en;
  assign infl_ph_d = ph_cur;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    img_d     = img_q;
    loaded_d  = loaded_q;
    rd_cnt_d  = rd_cnt_q + {31'd0, rd_en};
    tx_cnt_d  = tx_cnt_q + {31'd0, pop};
    res_d     = res_q;
    res_vld_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: if (i_start) begin
        num_d    = i_num_img;
        img_d    = '0;
        rd_cnt_d = '0;
        tx_cnt_d = '0;
        if (i_num_img == '0)                      state_d = DONE;
        else if (RELOAD_PARAMS == 0 && loaded_q)  state_d = LD_F;
        else                                      state_d = LD_W;
      end
      LD_W: if (last) state_d = LD_B;
      LD_B: if (last) begin
        state_d  = LD_F;
        loaded_d = 1'b1;
      end
      LD_F: if (last) state_d = WAIT_RES;
      WAIT_RES: if (i_result_en) begin
        res_d     = i_result;
        res_vld_d = 1'b1;
        img_d     = img_nx[IMG_BW-1:0];
        if (img_nx < {1'b0, num_q}) state_d = (RELOAD_PARAMS == 0) ? LD_F : LD_W;
        else                        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        img_d   = '0;
        if (RELOAD_PARAMS != 0) loaded_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (last) begin
      rd_cnt_d = '0;
      tx_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      img_q     <= '0;
      loaded_q  <= 1'b0;
      rd_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      infl_q    <= 1'b0;
      infl_ph_q <= 2'd0;
      cnt_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      res_q     <= 4'd0;
      res_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      num_q     <= num_d;
      img_q     <= img_d;
      loaded_q  <= loaded_d;
      rd_cnt_q  <= rd_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      infl_q    <= infl_d;
      infl_ph_q <= infl_ph_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      done_q    <= done_d;
    end
  end

  // FIFO storage carries no reset; the output mux below masks it while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= i_mem_data;
      fifo_ph_q[wr_ptr_q]   <= infl_ph_q;
    end
  end

  assign o_mem_re       = rd_en;
  assign o_mem_sel      = ph_cur;
  assign o_mem_addr     = ld_state ? base + rd_cnt_q[ADDR_BW-1:0] : '0;
  assign o_data         = vld ? fifo_data_q[rd_ptr_q] : '0;
  assign o_phase        = vld ? fifo_ph_q[rd_ptr_q] : 2'd0;
  assign o_data_valid   = vld;
  assign o_busy         = (state_q != IDLE);
  assign o_img_idx      = img_q;
  assign o_result       = res_q;
  assign o_result_valid = res_vld_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_lenet_stream_loader.sv
// Bench for lenet_stream_loader: random ready/result stimulus checked against an
// ordered expected-read / expected-stream model built from the run configuration.
module tb_lenet_stream_loader;
  localparam int DATA_BW  = 16;
  localparam int ADDR_BW  = 16;
  localparam int N_WEIGHT = 8;
  localparam int N_BIAS   = 2;
  localparam int N_FMAP   = 4;
  localparam int IMG_BW   = 8;

  logic               clk = 1'b0;
  logic               global_rst, ce, i_start;
  logic [IMG_BW-1:0]  i_num_img;
  logic               o_mem_re;
  logic [1:0]         o_mem_sel;
  logic [ADDR_BW-1:0] o_mem_addr;
  logic [DATA_BW-1:0] i_mem_data;
  logic [DATA_BW-1:0] o_data;
  logic               o_data_valid;
  logic [1:0]         o_phase;
  logic               i_data_ready;
  logic [3:0]         i_result;
  logic               i_result_en;
  logic               o_busy;
  logic [IMG_BW-1:0]  o_img_idx;
  logic [3:0]         o_result;
  logic               o_result_valid, o_done;

  always #5 clk = ~clk;

  lenet_stream_loader #(
    .DATA_BW(DATA_BW), .ADDR_BW(ADDR_BW), .N_WEIGHT(N_WEIGHT), .N_BIAS(N_BIAS),
    .N_FMAP(N_FMAP), .IMG_BW(IMG_BW), .RELOAD_PARAMS(0)
  ) dut (
    .clk(clk), .global_rst(global_rst), .ce(ce), .i_start(i_start), .i_num_img(i_num_img),
    .o_mem_re(o_mem_re), .o_mem_sel(o_mem_sel), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_phase(o_phase), .i_data_ready(i_data_ready),
    .i_result(i_result), .i_result_en(i_result_en), .o_busy(o_busy), .o_img_idx(o_img_idx),
    .o_result(o_result), .o_result_valid(o_result_valid), .o_done(o_done)
  );

  // Memory returns the address as data, one enabled cycle after the strobe.
  always @(posedge clk) if (ce && o_mem_re) i_mem_data <= o_mem_addr;

  int n_tests = 0, n_fail = 0;
  logic [17:0] exp_rd_q[$], exp_tx_q[$];
  int popped, outstanding, cyc, done_cnt, first_vld_cyc, last_pop_cyc, start_cyc;
  int ready_mode, ce_low_cnt;
  logic prev_ce, prev_vld, prev_rdy;
  logic [DATA_BW-1:0] prev_data;
  logic [1:0] prev_ph;
  logic [ADDR_BW-1:0] prev_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {11'd0, o_mem_re, o_mem_sel, o_mem_addr, o_data, o_data_valid, o_phase,
            o_busy, o_img_idx, o_result, o_result_valid, o_done};
  endfunction

  // Expected order: params once (if not yet loaded), then each image's pixel block.
  task automatic build(input int num, input bit with_params);
    logic [17:0] e;
    if (with_params) begin
      for (int w = 0; w < N_WEIGHT; w++) begin e = {2'd0, 16'(w)}; exp_rd_q.push_back(e); exp_tx_q.push_back(e); end
      for (int b = 0; b < N_BIAS; b++)   begin e = {2'd1, 16'(b)}; exp_rd_q.push_back(e); exp_tx_q.push_back(e); end
    end
    for (int im = 0; im < num; im++)
      for (int p = 0; p < N_FMAP; p++) begin
        e = {2'd2, 16'(im * N_FMAP + p)};
        exp_rd_q.push_back(e);
        exp_tx_q.push_back(e);
      end
  endtask

  task automatic monitor();
    logic [17:0] e;
    if (prev_ce === 1'b0) begin
      chk("hold_addr", o_mem_addr, prev_addr);
      chk("hold_data", {o_phase, o_data}, {prev_ph, prev_data});
      chk("hold_vld", o_data_valid, prev_vld);
    end else if (prev_vld && !prev_rdy) begin
      chk("stall_vld", o_data_valid, 1);
      chk("stall_data", {o_phase, o_data}, {prev_ph, prev_data});
    end
    if (!ce) chk("re_while_ce_low", o_mem_re, 0);
    else begin
      if (o_mem_re) begin
        e = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 18'h3FFFF;
        chk("rd_addr", {o_mem_sel, o_mem_addr}, e);
        outstanding++;
      end
      if (o_data_valid && i_data_ready) begin
        e = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 18'h3FFFF;
        chk("tx_data", {o_phase, o_data}, e);
        popped++;
        last_pop_cyc = cyc;
        outstanding--;
      end
      chk("outstanding_le2", 64'(outstanding <= 2), 1);
      if (o_done) done_cnt++;
    end
    if (o_data_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    prev_ce = ce; prev_vld = o_data_valid; prev_rdy = i_data_ready;
    prev_data = o_data; prev_ph = o_phase; prev_addr = o_mem_addr;
  endtask

  task automatic step();
    case (ready_mode)
      0:       i_data_ready = 1'b1;
      1:       i_data_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: i_data_ready = ($urandom % 4) != 0;
    endcase
    if (ce_low_cnt > 0) begin ce = 1'b0; ce_low_cnt--; end
    else ce = 1'b1;
    #2;
    monitor();
    @(negedge clk); #1;
    cyc++;
  endtask

  task automatic init_tb();
    exp_rd_q.delete(); exp_tx_q.delete();
    popped = 0; outstanding = 0; cyc = 0; done_cnt = 0; first_vld_cyc = -1; last_pop_cyc = -1;
    ce_low_cnt = 0; prev_ce = 1'b1; prev_vld = 1'b0; prev_rdy = 1'b1;
    prev_data = '0; prev_ph = '0; prev_addr = '0;
  endtask

  task automatic reset_dut();
    global_rst = 1'b1; ce = 1'b0; i_start = 1'b0; i_num_img = '0;
    i_data_ready = 1'b0; i_result = '0; i_result_en = 1'b0;
    repeat (2) @(negedge clk);
    global_rst = 1'b0; #1;
    ce = 1'b1;
    init_tb();
  endtask

  task automatic start_run(input int num);
    i_num_img = IMG_BW'(num); i_start = 1'b1;
    start_cyc = cyc; done_cnt = 0; first_vld_cyc = -1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_pops(input int target, input string tag);
    int k = 0;
    while (popped < target && k < 400) begin step(); k++; end
    if (popped < target) chk(tag, popped, target);
  endtask

  task automatic give_result(input logic [3:0] r, input int exp_idx);
    chk("wait_busy", o_busy, 1);
    chk("wait_no_data", o_data_valid, 0);
    i_result = r; i_result_en = 1'b1;
    step();
    i_result_en = 1'b0;
    chk("res_valid", o_result_valid, 1);
    chk("res_value", o_result, r);
    chk("img_idx", o_img_idx, exp_idx);
  endtask

  task automatic run_images(input int num, input bit params);
    int pre = params ? N_WEIGHT + N_BIAS : 0;
    for (int k = 0; k < num; k++) begin
      wait_pops(pre + (k + 1) * N_FMAP, "pop_timeout");
      give_result(4'($urandom_range(0, 15)), k + 1);
    end
  endtask

  task automatic finish_run();
    repeat (4) step();
    chk("done_once", done_cnt, 1);
    chk("idle_busy", o_busy, 0);
    chk("res_valid_drop", o_result_valid, 0);
    chk("rd_left", exp_rd_q.size(), 0);
    chk("tx_left", exp_tx_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    // Nominal two-image run with ready held high and exact timing.
    reset_dut();
    ready_mode = 0;
    chk("rst_outs", outs(), 0);
    build(2, 1);
    start_run(2);
    wait_pops(N_WEIGHT + N_BIAS + N_FMAP, "s1_img0");
    chk("s1_first_vld_lat", 64'(first_vld_cyc - start_cyc), 3);
    chk("s1_img0_last_pop", 64'(last_pop_cyc - start_cyc), 20);
    rc = cyc;
    give_result(4'd3, 1);
    wait_pops(N_WEIGHT + N_BIAS + 2 * N_FMAP, "s1_img1");
    chk("s1_img1_last_pop", 64'(last_pop_cyc - rc), 6);
    give_result(4'd5, 2);
    finish_run();
    chk("s1_final_result", o_result, 5);

    // Ready pattern 1,0,0,1.
    reset_dut();
    ready_mode = 1;
    build(2, 1);
    start_run(2);
    run_images(2, 1);
    finish_run();

    // Clock-enable low for five cycles in the middle of the pixel phase.
    reset_dut();
    ready_mode = 2;
    build(1, 1);
    start_run(1);
    wait_pops(N_WEIGHT + N_BIAS + 1, "s3_mid_fmap");
    ce_low_cnt = 5;
    run_images(1, 1);
    finish_run();

    // Asynchronous reset while biases load, then a fresh run.
    reset_dut();
    ready_mode = 2;
    build(2, 1);
    start_run(2);
    wait_pops(N_WEIGHT, "s4_weights");
    step(); step();
    chk("s4_busy_before_rst", o_busy, 1);
    ce = 1'b0; global_rst = 1'b1; #1;
    chk("s4_rst_outs", outs(), 0);
    @(negedge clk); @(negedge clk);
    global_rst = 1'b0; #1;
    init_tb();
    build(1, 1);
    start_run(1);
    run_images(1, 1);
    finish_run();

    // Zero-image run, ignored start, ignored result strobe.
    reset_dut();
    ready_mode = 0;
    start_run(0);
    chk("num0_busy", o_busy, 1);
    chk("num0_done_early", o_done, 0);
    step();
    chk("num0_done", o_done, 1);
    finish_run();
    build(1, 1);
    start_run(1);
    wait_pops(3, "s5_weights");
    i_num_img = 8'd5; i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_pops(N_WEIGHT + N_BIAS + 1, "s5_fmap");
    i_result = 4'hA; i_result_en = 1'b1;
    step();
    i_result_en = 1'b0;
    chk("ignored_res_valid", o_result_valid, 0);
    chk("ignored_res_value", o_result, 0);
    chk("ignored_img_idx", o_img_idx, 0);
    run_images(1, 1);
    finish_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
